// File: rtl/plazer_master_0_p2b_encoder_pkg.sv
// Shared definitions for the packet-to-byte encoder.
// Holds the framing symbols, the escape XOR mask, the FSM state encoding and
// a helper that classifies a byte as a framing symbol.
package plazer_master_0_p2b_encoder_pkg;

  localparam logic [7:0] SYM_SOP      = 8'h7A;
  localparam logic [7:0] SYM_EOP      = 8'h7B;
  localparam logic [7:0] SYM_CHAN     = 8'h7C;
  localparam logic [7:0] SYM_ESC      = 8'h7D;
  localparam logic [7:0] ESC_XOR_MASK = 8'h20;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHAN_MARK = 3'd1,
    CHAN_ESC  = 3'd2,
    CHAN_BYTE = 3'd3,
    SOP_MARK  = 3'd4,
    EOP_MARK  = 3'd5,
    DATA_ESC  = 3'd6,
    DATA_BYTE = 3'd7
  } p2b_state_e;

  // A byte collides with the framing alphabet when it lies in 0x7A..0x7D.
  function automatic logic is_special_byte(input logic [7:0] b);
    return (b >= SYM_SOP) && (b <= SYM_ESC);
  endfunction

endpackage

// File: rtl/plazer_p2b_escape_check.sv
// Escape classifier for one byte.
// Ports:
//   byte_i       - byte to be sent
//   is_special_o - byte collides with a framing symbol and needs an ESC prefix
//   byte_o       - byte as it goes on the wire after ESC (XORed when special)
module plazer_p2b_escape_check
  import plazer_master_0_p2b_encoder_pkg::*;
(
  input  logic [7:0] byte_i,
  output logic       is_special_o,
  output logic [7:0] byte_o
);

  // Classify the byte and form its post-escape value.
  always_comb begin
    is_special_o = is_special_byte(byte_i);
    if (is_special_o) begin
      byte_o = byte_i ^ ESC_XOR_MASK;
    end else begin
      byte_o = byte_i;
    end
  end

endmodule

// File: rtl/plazer_master_0_p2b_encoder.sv
// Packet-to-byte-stream encoder.
// Each accepted packet beat is turned into an optional channel marker plus
// channel byte, optional SOP/EOP markers and the data byte, with any byte
// that collides with the framing alphabet sent as ESC followed by byte^0x20.
// Ports:
//   clk, reset                 - clock, synchronous active-high reset
//   in_valid/in_ready          - packet beat handshake
//   in_data, in_channel        - beat payload byte and channel
//   in_startofpacket/endofpkt  - packet framing flags
//   out_valid/out_ready        - encoded byte handshake
//   out_data                   - encoded byte
module plazer_master_0_p2b_encoder
  import plazer_master_0_p2b_encoder_pkg::*;
#(
  parameter int ENCODE_CHANNEL = 1,
  parameter int CHANNEL_WIDTH  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     in_ready,
  input  logic                     in_valid,
  input  logic [7:0]               in_data,
  input  logic [CHANNEL_WIDTH-1:0] in_channel,
  input  logic                     in_startofpacket,
  input  logic                     in_endofpacket,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [7:0]               out_data
);

  p2b_state_e state_q, state_d;
  logic [7:0] data_q, data_d;
  logic [7:0] chan_q, chan_d;
  logic       sop_q, sop_d;
  logic       eop_q, eop_d;
  logic [7:0] last_chan_q, last_chan_d;

  logic [7:0] in_chan_ext_s;
  logic       accept_s;
  logic       chan_special_s;
  logic [7:0] chan_enc_s;
  logic       data_special_s;
  logic [7:0] data_enc_s;
  p2b_state_e new_beat_state_s;
  p2b_state_e data_state_s;
  p2b_state_e after_sop_s;
  p2b_state_e after_chan_s;

  plazer_p2b_escape_check u_chan_esc (
    .byte_i       (chan_q),
    .is_special_o (chan_special_s),
    .byte_o       (chan_enc_s)
  );

  plazer_p2b_escape_check u_data_esc (
    .byte_i       (data_q),
    .is_special_o (data_special_s),
    .byte_o       (data_enc_s)
  );

  // in_ready depends only on state and the sink, never on in_valid.
  assign in_ready = (state_q == IDLE) || ((state_q == DATA_BYTE) && out_ready);
  assign accept_s = in_valid && in_ready;

  // Zero-extend the incoming channel to a full byte.
  always_comb begin
    in_chan_ext_s = 8'h00;
    in_chan_ext_s[CHANNEL_WIDTH-1:0] = in_channel;
  end

  // First state for a beat being accepted this cycle, judged from the inputs.
  // last_chan_q is already current: it is updated when the previous beat's
  // channel byte completed, which precedes its DATA_BYTE.
  always_comb begin
    if ((ENCODE_CHANNEL != 0) &&
        (in_startofpacket || (in_chan_ext_s != last_chan_q))) begin
      new_beat_state_s = CHAN_MARK;
    end else if (in_startofpacket) begin
      new_beat_state_s = SOP_MARK;
    end else if (in_endofpacket) begin
      new_beat_state_s = EOP_MARK;
    end else if (is_special_byte(in_data)) begin
      new_beat_state_s = DATA_ESC;
    end else begin
      new_beat_state_s = DATA_BYTE;
    end
  end

  // Successor states for the held beat once each field has gone out.
  always_comb begin
    if (data_special_s) begin
      data_state_s = DATA_ESC;
    end else begin
      data_state_s = DATA_BYTE;
    end
    if (eop_q) begin
      after_sop_s = EOP_MARK;
    end else begin
      after_sop_s = data_state_s;
    end
    if (sop_q) begin
      after_chan_s = SOP_MARK;
    end else begin
      after_chan_s = after_sop_s;
    end
  end

  // Next-state logic, beat capture and last-channel tracking.
  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    chan_d      = chan_q;
    sop_d       = sop_q;
    eop_d       = eop_q;
    last_chan_d = last_chan_q;

    if (accept_s) begin
      data_d = in_data;
      chan_d = (ENCODE_CHANNEL != 0) ? in_chan_ext_s : 8'h00;
      sop_d  = in_startofpacket;
      eop_d  = in_endofpacket;
    end else begin
      data_d = data_q;
    end

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = new_beat_state_s;
        end else begin
          state_d = IDLE;
        end
      end
      CHAN_MARK: begin
        if (out_ready) begin
          state_d = chan_special_s ? CHAN_ESC : CHAN_BYTE;
        end else begin
          state_d = CHAN_MARK;
        end
      end
      CHAN_ESC: begin
        if (out_ready) begin
          state_d = CHAN_BYTE;
        end else begin
          state_d = CHAN_ESC;
        end
      end
      CHAN_BYTE: begin
        if (out_ready) begin
          state_d     = after_chan_s;
          last_chan_d = chan_q;
        end else begin
          state_d = CHAN_BYTE;
        end
      end
      SOP_MARK: begin
        if (out_ready) begin
          state_d = after_sop_s;
        end else begin
          state_d = SOP_MARK;
        end
      end
      EOP_MARK: begin
        if (out_ready) begin
          state_d = data_state_s;
        end else begin
          state_d = EOP_MARK;
        end
      end
      DATA_ESC: begin
        if (out_ready) begin
          state_d = DATA_BYTE;
        end else begin
          state_d = DATA_ESC;
        end
      end
      DATA_BYTE: begin
        // Chaining straight into the next beat keeps one byte per cycle.
        if (out_ready && in_valid) begin
          state_d = new_beat_state_s;
        end else if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DATA_BYTE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output byte decode from state and held beat only.
  always_comb begin
    out_valid = 1'b0;
    out_data  = 8'h00;
    case (state_q)
      IDLE: begin
        out_valid = 1'b0;
        out_data  = 8'h00;
      end
      CHAN_MARK: begin
        out_valid = 1'b1;
        out_data  = SYM_CHAN;
      end
      CHAN_ESC, DATA_ESC: begin
        out_valid = 1'b1;
        out_data  = SYM_ESC;
      end
      CHAN_BYTE: begin
        out_valid = 1'b1;
        out_data  = chan_enc_s;
      end
      SOP_MARK: begin
        out_valid = 1'b1;
        out_data  = SYM_SOP;
      end
      EOP_MARK: begin
        out_valid = 1'b1;
        out_data  = SYM_EOP;
      end
      DATA_BYTE: begin
        out_valid = 1'b1;
        out_data  = data_enc_s;
      end
      default: begin
        out_valid = 1'b0;
        out_data  = 8'h00;
      end
    endcase
  end

  // State and holding registers; reset drops any partially sent beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      data_q      <= 8'h00;
      chan_q      <= 8'h00;
      sop_q       <= 1'b0;
      eop_q       <= 1'b0;
      last_chan_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      chan_q      <= chan_d;
      sop_q       <= sop_d;
      eop_q       <= eop_d;
      last_chan_q <= last_chan_d;
    end
  end

endmodule

// File: tb/tb_plazer_master_0_p2b_encoder.sv
// Self-checking bench for plazer_master_0_p2b_encoder.
// Instance dut_a uses channel encoding, dut_b has ENCODE_CHANNEL=0.
// Expected bytes come from a small encoding model into a scoreboard queue.
module tb_plazer_master_0_p2b_encoder;

  typedef struct {
    logic [7:0] d;
    logic [7:0] ch;
    logic       sop;
    logic       eop;
  } beat_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       a_in_ready, a_in_valid, a_sop, a_eop, a_out_ready, a_out_valid;
  logic [7:0] a_in_data, a_in_channel, a_out_data;
  logic       b_in_ready, b_in_valid, b_sop, b_eop, b_out_ready, b_out_valid;
  logic [7:0] b_in_data, b_in_channel, b_out_data;

  plazer_master_0_p2b_encoder #(.ENCODE_CHANNEL(1), .CHANNEL_WIDTH(8)) dut_a (
    .clk(clk), .reset(reset), .in_ready(a_in_ready), .in_valid(a_in_valid),
    .in_data(a_in_data), .in_channel(a_in_channel),
    .in_startofpacket(a_sop), .in_endofpacket(a_eop),
    .out_ready(a_out_ready), .out_valid(a_out_valid), .out_data(a_out_data)
  );

  plazer_master_0_p2b_encoder #(.ENCODE_CHANNEL(0), .CHANNEL_WIDTH(8)) dut_b (
    .clk(clk), .reset(reset), .in_ready(b_in_ready), .in_valid(b_in_valid),
    .in_data(b_in_data), .in_channel(b_in_channel),
    .in_startofpacket(b_sop), .in_endofpacket(b_eop),
    .out_ready(b_out_ready), .out_valid(b_out_valid), .out_data(b_out_data)
  );

  int checks = 0;
  int passes = 0;
  int cyc = 0;

  beat_t      beat_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];
  int         obs_cyc_q[$];
  int         acc_cyc_q[$];
  logic [7:0] stall_data_q[$];
  logic       stall_rdy_q[$];
  logic [7:0] m_last_a;

  // Free-running cycle index used for latency and throughput checks.
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void push_esc(input logic [7:0] b);
    if (b >= 8'h7A && b <= 8'h7D) begin
      exp_q.push_back(8'h7D);
      exp_q.push_back(b ^ 8'h20);
    end else begin
      exp_q.push_back(b);
    end
  endfunction

  // Queue a beat for the driver and push the bytes it must produce.
  task automatic queue_beat(input bit nc, input logic [7:0] d, input logic [7:0] ch,
                            input logic s, input logic e);
    beat_t bt;
    bt = '{d, ch, s, e};
    beat_q.push_back(bt);
    if (!nc && (s || ch != m_last_a)) begin
      exp_q.push_back(8'h7C);
      push_esc(ch);
      m_last_a = ch;
    end
    if (s) exp_q.push_back(8'h7A);
    if (e) exp_q.push_back(8'h7B);
    push_esc(d);
  endtask

  task automatic idle_inputs();
    a_in_valid = 1'b0; a_in_data = 8'h00; a_in_channel = 8'h00; a_sop = 1'b0; a_eop = 1'b0;
    b_in_valid = 1'b0; b_in_data = 8'h00; b_in_channel = 8'h00; b_sop = 1'b0; b_eop = 1'b0;
    a_out_ready = 1'b1;
    b_out_ready = 1'b1;
  endtask

  // Drive queued beats and collect output bytes; mode 0 ready high,
  // 1 random ready, 2 hold ready low for the first three cycles showing 0x7A.
  task automatic run_stream(input bit nc, input int mode, input int budget);
    int n; int target; int stalls;
    logic ov, ir, rdy;
    logic [7:0] od;
    beat_t bt;
    n = 0; stalls = 0; target = exp_q.size();
    obs_q.delete(); obs_cyc_q.delete(); acc_cyc_q.delete();
    stall_data_q.delete(); stall_rdy_q.delete();
    while ((beat_q.size() != 0 || obs_q.size() < target) && n < budget) begin
      @(negedge clk);
      if (beat_q.size() != 0) bt = beat_q[0];
      else bt = '{8'h00, 8'h00, 1'b0, 1'b0};
      if (nc) begin
        b_in_valid = (beat_q.size() != 0); b_in_data = bt.d; b_in_channel = bt.ch;
        b_sop = bt.sop; b_eop = bt.eop;
      end else begin
        a_in_valid = (beat_q.size() != 0); a_in_data = bt.d; a_in_channel = bt.ch;
        a_sop = bt.sop; a_eop = bt.eop;
      end
      #1;
      ov = nc ? b_out_valid : a_out_valid;
      od = nc ? b_out_data : a_out_data;
      if (mode == 1) rdy = 1'($urandom_range(0, 1));
      else if (mode == 2 && ov && od == 8'h7A && stalls < 3) begin
        rdy = 1'b0;
        stalls++;
      end else rdy = 1'b1;
      if (nc) b_out_ready = rdy;
      else a_out_ready = rdy;
      #1;
      ir = nc ? b_in_ready : a_in_ready;
      if (mode == 2 && !rdy) begin
        stall_data_q.push_back(nc ? b_out_data : a_out_data);
        stall_rdy_q.push_back(ir);
      end
      if (ov && rdy) begin
        obs_q.push_back(od);
        obs_cyc_q.push_back(cyc);
      end
      if (beat_q.size() != 0 && ir) begin
        acc_cyc_q.push_back(cyc);
        bt = beat_q.pop_front();
      end
      n++;
    end
    @(negedge clk);
    idle_inputs();
    beat_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    repeat (3) @(negedge clk);
    checks++; if (a_out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", a_out_valid); else passes++;
    checks++; if (a_out_data !== 8'h00) $display("FAIL reset_out_data got %h want 00", a_out_data); else passes++;
    checks++; if (b_out_valid !== 1'b0) $display("FAIL reset_b_out_valid got %b want 0", b_out_valid); else passes++;
    reset = 1'b0;
    @(negedge clk);
    checks++; if (a_in_ready !== 1'b1) $display("FAIL post_reset_in_ready got %b want 1", a_in_ready); else passes++;
    checks++; if (b_in_ready !== 1'b1) $display("FAIL post_reset_b_in_ready got %b want 1", b_in_ready); else passes++;
    checks++; if (a_out_valid !== 1'b0) $display("FAIL post_reset_out_valid got %b want 0", a_out_valid); else passes++;
    m_last_a = 8'h00;
  endtask

  task automatic test_single_beat();
    int n_exp; logic [7:0] e;
    queue_beat(1'b0, 8'h41, 8'h00, 1'b1, 1'b1);
    n_exp = exp_q.size();
    run_stream(1'b0, 0, 100);
    checks++; if (obs_q.size() != n_exp) $display("FAIL single_count got %0d want %0d", obs_q.size(), n_exp); else passes++;
    for (int i = 0; i < obs_q.size() && exp_q.size() != 0; i++) begin
      e = exp_q.pop_front();
      checks++; if (obs_q[i] !== e) $display("FAIL single_byte%0d got %h want %h", i, obs_q[i], e); else passes++;
    end
    if (obs_cyc_q.size() != 0 && acc_cyc_q.size() != 0) begin
      checks++;
      if (obs_cyc_q[0] != acc_cyc_q[0] + 1)
        $display("FAIL single_latency got %0d want %0d", obs_cyc_q[0] - acc_cyc_q[0], 1);
      else passes++;
    end
    exp_q.delete();
  endtask

  task automatic test_escape_data();
    int n_exp; logic [7:0] e;
    queue_beat(1'b0, 8'h7D, 8'h00, 1'b0, 1'b0);
    queue_beat(1'b0, 8'h7A, 8'h00, 1'b0, 1'b1);
    n_exp = exp_q.size();
    run_stream(1'b0, 0, 100);
    checks++; if (obs_q.size() != n_exp) $display("FAIL esc_count got %0d want %0d", obs_q.size(), n_exp); else passes++;
    for (int i = 0; i < obs_q.size() && exp_q.size() != 0; i++) begin
      e = exp_q.pop_front();
      checks++; if (obs_q[i] !== e) $display("FAIL esc_byte%0d got %h want %h", i, obs_q[i], e); else passes++;
    end
    exp_q.delete();
  endtask

  task automatic test_channel_change();
    int n_exp; logic [7:0] e;
    queue_beat(1'b0, 8'h11, 8'h03, 1'b1, 1'b0);
    queue_beat(1'b0, 8'h10, 8'h05, 1'b0, 1'b0);
    queue_beat(1'b0, 8'h33, 8'h7A, 1'b0, 1'b1);
    n_exp = exp_q.size();
    run_stream(1'b0, 1, 300);
    checks++; if (obs_q.size() != n_exp) $display("FAIL chan_count got %0d want %0d", obs_q.size(), n_exp); else passes++;
    for (int i = 0; i < obs_q.size() && exp_q.size() != 0; i++) begin
      e = exp_q.pop_front();
      checks++; if (obs_q[i] !== e) $display("FAIL chan_byte%0d got %h want %h", i, obs_q[i], e); else passes++;
    end
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    int n_exp; logic [7:0] e;
    for (int k = 0; k < 6; k++) queue_beat(1'b0, 8'(8'h20 + k), 8'h7A, 1'b0, 1'b0);
    n_exp = exp_q.size();
    run_stream(1'b0, 0, 100);
    checks++; if (obs_q.size() != n_exp) $display("FAIL b2b_count got %0d want %0d", obs_q.size(), n_exp); else passes++;
    for (int i = 0; i < obs_q.size() && exp_q.size() != 0; i++) begin
      e = exp_q.pop_front();
      checks++; if (obs_q[i] !== e) $display("FAIL b2b_byte%0d got %h want %h", i, obs_q[i], e); else passes++;
    end
    for (int i = 1; i < obs_cyc_q.size(); i++) begin
      checks++;
      if (obs_cyc_q[i] != obs_cyc_q[i-1] + 1)
        $display("FAIL b2b_gap%0d got %0d want 1", i, obs_cyc_q[i] - obs_cyc_q[i-1]);
      else passes++;
    end
    exp_q.delete();
  endtask

  task automatic test_stall_sop();
    int n_exp; logic [7:0] e;
    queue_beat(1'b0, 8'h55, 8'h01, 1'b1, 1'b0);
    queue_beat(1'b0, 8'h56, 8'h01, 1'b0, 1'b1);
    n_exp = exp_q.size();
    run_stream(1'b0, 2, 100);
    checks++; if (stall_data_q.size() != 3) $display("FAIL stall_cycles got %0d want 3", stall_data_q.size()); else passes++;
    for (int i = 0; i < stall_data_q.size(); i++) begin
      checks++; if (stall_data_q[i] !== 8'h7A) $display("FAIL stall_data%0d got %h want 7a", i, stall_data_q[i]); else passes++;
      checks++; if (stall_rdy_q[i] !== 1'b0) $display("FAIL stall_in_ready%0d got %b want 0", i, stall_rdy_q[i]); else passes++;
    end
    checks++; if (obs_q.size() != n_exp) $display("FAIL stall_count got %0d want %0d", obs_q.size(), n_exp); else passes++;
    for (int i = 0; i < obs_q.size() && exp_q.size() != 0; i++) begin
      e = exp_q.pop_front();
      checks++; if (obs_q[i] !== e) $display("FAIL stall_byte%0d got %h want %h", i, obs_q[i], e); else passes++;
    end
    exp_q.delete();
  endtask

  task automatic test_reset_mid();
    int n_exp; logic [7:0] e;
    // Same channel as last beat, so the DUT goes straight to DATA_ESC.
    @(negedge clk);
    a_in_valid = 1'b1; a_in_data = 8'h7D; a_in_channel = 8'h01; a_sop = 1'b0; a_eop = 1'b0;
    a_out_ready = 1'b0;
    #1;
    checks++; if (a_in_ready !== 1'b1) $display("FAIL rmid_accept got %b want 1", a_in_ready); else passes++;
    @(negedge clk);
    a_in_valid = 1'b0;
    #1;
    checks++; if (a_out_data !== 8'h7D) $display("FAIL rmid_pending got %h want 7d", a_out_data); else passes++;
    reset = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (a_out_valid !== 1'b0) $display("FAIL rmid_out_valid got %b want 0", a_out_valid); else passes++;
    checks++; if (a_out_data !== 8'h00) $display("FAIL rmid_out_data got %h want 00", a_out_data); else passes++;
    reset = 1'b0;
    a_out_ready = 1'b1;
    m_last_a = 8'h00;
    queue_beat(1'b0, 8'h22, 8'h00, 1'b0, 1'b0);
    queue_beat(1'b0, 8'h41, 8'h00, 1'b1, 1'b1);
    n_exp = exp_q.size();
    run_stream(1'b0, 0, 100);
    checks++; if (obs_q.size() != n_exp) $display("FAIL rmid_count got %0d want %0d", obs_q.size(), n_exp); else passes++;
    for (int i = 0; i < obs_q.size() && exp_q.size() != 0; i++) begin
      e = exp_q.pop_front();
      checks++; if (obs_q[i] !== e) $display("FAIL rmid_byte%0d got %h want %h", i, obs_q[i], e); else passes++;
    end
    exp_q.delete();
  endtask

  task automatic test_no_channel();
    int n_exp; logic [7:0] e;
    queue_beat(1'b1, 8'h01, 8'h09, 1'b1, 1'b0);
    queue_beat(1'b1, 8'h02, 8'h08, 1'b0, 1'b0);
    queue_beat(1'b1, 8'h03, 8'h07, 1'b0, 1'b0);
    queue_beat(1'b1, 8'h04, 8'h06, 1'b0, 1'b1);
    n_exp = exp_q.size();
    run_stream(1'b1, 0, 100);
    checks++; if (obs_q.size() != n_exp) $display("FAIL nochan_count got %0d want %0d", obs_q.size(), n_exp); else passes++;
    for (int i = 0; i < obs_q.size() && exp_q.size() != 0; i++) begin
      e = exp_q.pop_front();
      checks++; if (obs_q[i] !== e) $display("FAIL nochan_byte%0d got %h want %h", i, obs_q[i], e); else passes++;
    end
    for (int i = 1; i < obs_cyc_q.size(); i++) begin
      checks++;
      if (obs_cyc_q[i] != obs_cyc_q[i-1] + 1)
        $display("FAIL nochan_gap%0d got %0d want 1", i, obs_cyc_q[i] - obs_cyc_q[i-1]);
      else passes++;
    end
    exp_q.delete();
  endtask

  initial begin
    m_last_a = 8'h00;
    test_reset();
    test_single_beat();
    test_escape_data();
    test_channel_change();
    test_back_to_back();
    test_stall_sop();
    test_reset_mid();
    test_no_channel();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/plazer_master_0_p2b_encoder.md
PLAZER_MASTER_0_P2B_ENCODER -- requirements
Module: plazer_master_0_p2b_encoder

Interface
REQ-001 Parameter ENCODE_CHANNEL, default 1: 1 = emit channel markers, 0 = ignore in_channel.
REQ-002 Parameter CHANNEL_WIDTH, default 8: width of in_channel, 1..8.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_ready  output  1  encoder accepts the current packet beat.
REQ-006 in_valid  input  1  packet beat valid.
REQ-007 in_data  input  8  packet payload byte.
REQ-008 in_channel  input  CHANNEL_WIDTH  packet channel.
REQ-009 in_startofpacket  input  1  first beat of packet.
REQ-010 in_endofpacket  input  1  last beat of packet.
REQ-011 out_ready  input  1  byte sink accepts out_data.
REQ-012 out_valid  output  1  encoded byte valid.
REQ-013 out_data  output  8  encoded byte stream.

Function
REQ-014 Special bytes: SOP=0x7A, EOP=0x7B, CHAN=0x7C, ESC=0x7D; a byte is special when in 0x7A..0x7D.
REQ-015 Beat transfer when in_valid && in_ready; beat (data, channel, sop, eop) is captured into a holding register.
REQ-016 Per beat, emit in order: [CHAN, channel byte] if ENCODE_CHANNEL && (sop || channel != last_channel); [SOP] if sop; [EOP] if eop; data byte.
REQ-017 Channel byte and data byte that are special are sent as ESC then (byte XOR 0x20); channel byte is zero-extended to 8 bits.
REQ-018 last_channel updated to captured channel when the channel byte completes.
REQ-019 FSM states: IDLE, CHAN_MARK, CHAN_ESC, CHAN_BYTE, SOP_MARK, EOP_MARK, DATA_ESC, DATA_BYTE; from IDLE on transfer go to first applicable state per REQ-016, each state advances to next applicable state only when out_ready, DATA_BYTE returns to IDLE or directly to first state of a new beat.
REQ-020 out_valid = 1 in every state except IDLE; out_data is a function of state and holding register only (CHAN_MARK->0x7C, SOP_MARK->0x7A, EOP_MARK->0x7B, *_ESC->0x7D, *_BYTE->byte or byte^0x20 if escaped).
REQ-021 out_data and out_valid stay stable while out_valid && !out_ready.
REQ-022 in_ready = (state==IDLE) || (state==DATA_BYTE && out_ready); no combinational path from in_valid to in_ready.
REQ-023 Latency: beat accepted at edge N, its first encoded byte visible in cycle N+1.
REQ-024 Throughput: back-to-back non-special data bytes with no markers sustain one output byte per cycle with out_ready high.
REQ-025 sop && eop in one beat: SOP then EOP then data.
REQ-026 Beat with in_valid low is ignored; in_channel/in_data unaffected by non-transfer cycles.

Reset
REQ-027 On reset: state=IDLE, out_valid=0, out_data=0x00, in_ready=1 after reset deasserts, last_channel=0, holding register cleared.
REQ-028 Reset mid-sequence abandons the partially sent beat; no residual bytes after reset.

Structure
REQ-029 Shared package holds the four special-byte constants, escape XOR mask 0x20, and FSM state enumeration.
REQ-030 Single flat module; one natural helper sub-module plazer_p2b_escape_check (byte in -> is_special flag, escaped byte).

Verification
REQ-031 Single beat data=0x41 sop=1 eop=1 ch=0 -> 0x7C,0x00,0x7A,0x7B,0x41.
REQ-032 Data 0x7D mid-packet, same channel -> 0x7D,0x5D.
REQ-033 Packet ch=3 then mid-packet beat ch=5 data=0x10 -> 0x7C,0x05,0x10; ch=0x7A -> 0x7C,0x7D,0x5A.
REQ-034 out_ready held low 3 cycles during SOP_MARK -> out_data stays 0x7A, in_ready=0, no beat lost.
REQ-035 Reset asserted while DATA_ESC pending -> next cycle out_valid=0; next packet encodes from CHAN_MARK cleanly.
REQ-036 ENCODE_CHANNEL=0, 4 beats data 0x01..0x04, sop on first, eop on last -> 0x7A,0x01,0x02,0x03,0x7B,0x04 at 1 byte/cycle after SOP.
